// File: rtl/sba_pkg.sv
// Shared types and default SoC address map for the SBA interconnect.
package sba_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_ERR
  } sba_state_t;

  localparam logic CAUSE_MISS    = 1'b0;
  localparam logic CAUSE_TIMEOUT = 1'b1;

  localparam logic [31:0] BRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] BRAM_MASK  = 32'hFF00_0000;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK = 32'hFF00_0000;
  localparam logic [31:0] PLIC_BASE  = 32'h0C00_0000;
  localparam logic [31:0] PLIC_MASK  = 32'hFF00_0000;
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] SPI_BASE   = 32'h1000_1000;
  localparam logic [31:0] SPI_MASK   = 32'hFFFF_F000;
  localparam logic [31:0] SRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] SRAM_MASK  = 32'hFF00_0000;

  // Slave k lives at bits [k*32 +: 32], so slave 0 is rightmost.
  localparam logic [6*32-1:0] DEF_BASE = {
    SRAM_BASE, SPI_BASE, UART_BASE,
    PLIC_BASE, CLINT_BASE, BRAM_BASE
  };
  localparam logic [6*32-1:0] DEF_MASK = {
    SRAM_MASK, SPI_MASK, UART_MASK,
    PLIC_MASK, CLINT_MASK, BRAM_MASK
  };

endpackage

// File: rtl/sba_decode.sv
// Base/mask address match with a lowest-index-wins priority encoder.
module sba_decode #(
  parameter int N  = 6,
  parameter int AW = 32,
  parameter int SW = 3,
  parameter logic [N*AW-1:0] BASE = '0,
  parameter logic [N*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_hit,
  output logic [SW-1:0] o_idx
);

  // Scan downwards so the lowest matching index is written last.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((i_addr & MASK[k*AW +: AW]) ==
          (BASE[k*AW +: AW] & MASK[k*AW +: AW])) begin
        o_hit = 1'b1;
        o_idx = SW'(k);
      end
    end
  end

endmodule

// File: rtl/sba_interconnect.sv
// Single-master, N-slave SBA interconnect with registered decode,
// per-access timeout and sticky bus-error capture.
module sba_interconnect
  import sba_pkg::*;
#(
  parameter int N_SLAVES = 6,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK,
  parameter int TIMEOUT  = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_W-1:0]          i_m_addr,
  input  logic [DATA_W-1:0]          i_m_dat_w,
  input  logic [DATA_W/8-1:0]        i_m_we,
  input  logic                       i_m_stb,
  output logic [DATA_W-1:0]          o_m_dat_r,
  output logic                       o_m_ack,
  output logic                       o_m_err,
  output logic [N_SLAVES-1:0]        o_s_stb,
  output logic [ADDR_W-1:0]          o_s_addr,
  output logic [DATA_W-1:0]          o_s_dat_w,
  output logic [DATA_W/8-1:0]        o_s_we,
  input  logic [N_SLAVES*DATA_W-1:0] i_s_dat_r,
  input  logic [N_SLAVES-1:0]        i_s_ack,
  output logic                       o_err_valid,
  output logic [ADDR_W-1:0]          o_err_addr,
  output logic                       o_err_cause,
  input  logic                       i_err_clr
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  sba_state_t        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              pcause_q, pcause_d;
  logic              ev_q, ev_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              ec_q, ec_d;

  logic              hit;
  logic [SEL_W-1:0]  hit_idx;

  sba_decode #(
    .N    (N_SLAVES),
    .AW   (ADDR_W),
    .SW   (SEL_W),
    .BASE (SLAVE_BASE),
    .MASK (SLAVE_MASK)
  ) u_decode (
    .i_addr (i_m_addr),
    .o_hit  (hit),
    .o_idx  (hit_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      dat_q    <= '0;
      pcause_q <= CAUSE_MISS;
      ev_q     <= 1'b0;
      ea_q     <= '0;
      ec_q     <= CAUSE_MISS;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      pcause_q <= pcause_d;
      ev_q     <= ev_d;
      ea_q     <= ea_d;
      ec_q     <= ec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    pcause_d = pcause_q;
    ev_d     = ev_q;
    ea_d     = ea_q;
    ec_d     = ec_q;
    if (i_err_clr) ev_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_m_stb) begin
          if (hit) begin
            sel_d   = hit_idx;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            pcause_d = CAUSE_MISS;
            state_d  = S_ERR;
          end
        end
      end
      S_WAIT: begin
        // An ack on the terminal-count cycle beats the timeout.
        if (i_s_ack[sel_q]) begin
          dat_d   = i_s_dat_r[sel_q*DATA_W +: DATA_W];
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          pcause_d = CAUSE_TIMEOUT;
          state_d  = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        dat_d   = '0;
        ea_d    = i_m_addr;
        ec_d    = pcause_q;
        ev_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_s_stb     = (state_q == S_WAIT) ?
                       (N_SLAVES'(1) << sel_q) : '0;
  assign o_s_we      = (state_q == S_WAIT) ? i_m_we : '0;
  assign o_s_addr    = i_m_addr;
  assign o_s_dat_w   = i_m_dat_w;
  assign o_m_ack     = (state_q == S_RESP);
  assign o_m_err     = (state_q == S_ERR);
  assign o_m_dat_r   = dat_q;
  assign o_err_valid = ev_q;
  assign o_err_addr  = ea_q;
  assign o_err_cause = ec_q;

endmodule

// File: tb/tb_sba_interconnect.sv
// Randomised bench for sba_interconnect against a transaction-level model.
module tb_sba_interconnect;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_dw;
  logic [BW-1:0]   m_we;
  logic            m_stb;
  logic [DW-1:0]   m_dr;
  logic            m_ack;
  logic            m_err;
  logic [N-1:0]    s_stb;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_dw;
  logic [BW-1:0]   s_we;
  logic [N*DW-1:0] s_dr;
  logic [N-1:0]    s_ack;
  logic            ev;
  logic [AW-1:0]   ea;
  logic            ec;
  logic            clr;

  sba_interconnect #(
    .N_SLAVES (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_m_addr    (m_addr),
    .i_m_dat_w   (m_dw),
    .i_m_we      (m_we),
    .i_m_stb     (m_stb),
    .o_m_dat_r   (m_dr),
    .o_m_ack     (m_ack),
    .o_m_err     (m_err),
    .o_s_stb     (s_stb),
    .o_s_addr    (s_addr),
    .o_s_dat_w   (s_dw),
    .o_s_we      (s_we),
    .i_s_dat_r   (s_dr),
    .i_s_ack     (s_ack),
    .o_err_valid (ev),
    .o_err_addr  (ea),
    .o_err_cause (ec),
    .i_err_clr   (clr)
  );

  logic [31:0] map_b [N] = '{32'h0000_0000, 32'h0200_0000,
                             32'h0C00_0000, 32'h1000_0000,
                             32'h1000_1000, 32'h8000_0000};
  logic [31:0] map_m [N] = '{32'hFF00_0000, 32'hFF00_0000,
                             32'hFF00_0000, 32'hFFFF_F000,
                             32'hFFFF_F000, 32'hFF00_0000};

  int total = 0;
  int bad = 0;
  bit clr_en = 0;

  logic [DW-1:0] m_dat;
  logic          m_ev;
  logic [AW-1:0] m_ea;
  logic          m_ec;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // One master access; caller is 1 time unit after a posedge, DUT idle.
  // ack_at: cycle the selected slave acks (0 or >TO means never).
  task automatic access(input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rd, input bit spur);
    bit hit;
    bit ok;
    int k;
    int done;
    bit wc;
    logic [N-1:0] onehot;
    hit = 0;
    k = 0;
    for (int i = 0; i < N; i++)
      if (!hit && ((a & map_m[i]) == (map_b[i] & map_m[i]))) begin
        hit = 1;
        k = i;
      end
    ok = hit && ack_at >= 1 && ack_at <= TO;
    done = !hit ? 1 : (ok ? ack_at + 1 : TO + 1);
    onehot = N'(1) << k;
    for (int c = 0; c <= done + 1; c++) begin
      m_stb = (c <= done);
      m_addr = a;
      m_dw = wd;
      m_we = we;
      for (int j = 0; j < N; j++) s_dr[j*DW +: DW] = $urandom;
      if (hit) s_dr[k*DW +: DW] = rd;
      s_ack = spur ? (N'($urandom) | N'(2)) : '0;
      if (hit) s_ack[k] = ok && (c == ack_at);
      clr = clr_en && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      wc = hit && c >= 1 && c < done;
      chk("s_stb", 64'(s_stb), wc ? 64'(onehot) : 64'd0);
      chk("s_we", 64'(s_we), wc ? 64'(we) : 64'd0);
      chk("m_ack", 64'(m_ack), 64'(ok && c == done));
      chk("m_err", 64'(m_err), 64'(!ok && c == done));
      chk("s_addr", 64'(s_addr), 64'(a));
      chk("s_dat_w", 64'(s_dw), 64'(wd));
      chk("m_dat_r", 64'(m_dr), 64'(m_dat));
      chk("err_valid", 64'(ev), 64'(m_ev));
      chk("err_addr", 64'(ea), 64'(m_ea));
      chk("err_cause", 64'(ec), 64'(m_ec));
      if (!ok && c == done) begin
        m_ev = 1;
        m_ea = a;
        m_ec = hit;
        m_dat = '0;
      end else if (clr) begin
        m_ev = 0;
      end
      if (ok && c == ack_at) m_dat = rd;
      @(posedge clk);
      #1;
    end
    clr = 0;
  endtask

  task automatic reset_mid(input logic [31:0] a);
    m_stb = 1;
    m_addr = a;
    m_we = '0;
    s_ack = '0;
    clr = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pre_stb", 64'(s_stb), 64'h20);
    rst_n = 0;
    #1;
    chk("rst_stb", 64'(s_stb), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_ev", 64'(ev), 64'd0);
    chk("rst_ea", 64'(ea), 64'd0);
    chk("rst_dat", 64'(m_dr), 64'd0);
    m_stb = 0;
    m_dat = '0;
    m_ev = 0;
    m_ea = '0;
    m_ec = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    m_stb = 0;
    m_addr = '0;
    m_dw = '0;
    m_we = '0;
    s_dr = '0;
    s_ack = '0;
    clr = 0;
    m_dat = '0;
    m_ev = 0;
    m_ea = '0;
    m_ec = 0;
    #2;
    chk("reset_stb", 64'(s_stb), 64'd0);
    chk("reset_ack", 64'(m_ack), 64'd0);
    chk("reset_err", 64'(m_err), 64'd0);
    chk("reset_ev", 64'(ev), 64'd0);
    chk("reset_dat", 64'(m_dr), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    access(32'h0000_0010, 4'h0, 32'h0, 2, 32'hDEAD_BEEF, 0);
    chk("t1_dat", 64'(m_dr), 64'hDEAD_BEEF);

    access(32'h4000_0000, 4'h0, 32'h0, 0, 32'h0, 0);
    chk("t2_ev", 64'(ev), 64'd1);
    chk("t2_ea", 64'(ea), 64'h4000_0000);
    chk("t2_ec", 64'(ec), 64'd0);
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    m_ev = 0;
    chk("t2_clr", 64'(ev), 64'd0);

    access(32'h1000_1004, 4'h0, 32'h0, 99, 32'h0, 0);
    chk("t3_ec", 64'(ec), 64'd1);
    chk("t3_ea", 64'(ea), 64'h1000_1004);
    chk("t3_dat", 64'(m_dr), 64'd0);

    access(32'h1000_1004, 4'h0, 32'h0, 16, 32'h5555_AAAA, 0);
    chk("t4_dat", 64'(m_dr), 64'h5555_AAAA);
    chk("t4_ev", 64'(ev), 64'd1);

    access(32'h8000_0008, 4'b0011, 32'h1234_ABCD, 3, 32'h0BAD_F00D, 1);
    chk("t5_dat", 64'(m_dr), 64'h0BAD_F00D);

    access(32'h4000_0100, 4'h0, 32'h0, 0, 32'h0, 0);
    reset_mid(32'h8000_0040);
    access(32'h0200_0004, 4'h0, 32'h0, 1, 32'hCAFE_0001, 0);
    chk("t6_dat", 64'(m_dr), 64'hCAFE_0001);

    clr_en = 1;
    repeat (150) begin
      r = $urandom_range(0, 7);
      if (r < N)
        a = (map_b[r] & map_m[r]) | ($urandom & ~map_m[r]);
      else if (r == 6)
        a = 32'h4000_0000 | ($urandom & 32'h00FF_FFFF);
      else
        a = 32'h1000_2000 + $urandom_range(0, 32'hFFF);
      access(a, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
             $urandom, $urandom_range(1, 20), $urandom,
             bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
